// File: rtl/mux_n_pipe.sv
// N-input, W-bit operand selector registered behind a 1- or 2-slice valid/ready pipe.
// Out-of-range selects inject DEFAULT_VAL and feed a sticky flag plus saturating counter.
module mux_n_pipe #(
  parameter int                WIDTH       = 32,
  parameter int                NUM_INPUTS  = 3,
  parameter int                SEL_W       = 2,
  parameter int                PIPE_STAGES = 1,
  parameter logic [WIDTH-1:0]  DEFAULT_VAL = '0
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_INPUTS*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]            sel,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic [WIDTH-1:0]            out_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        sel_err,
  output logic [7:0]                  err_count,
  input  logic                        err_clr
);

  if (NUM_INPUTS < 2 || NUM_INPUTS > 16 || (PIPE_STAGES != 1 && PIPE_STAGES != 2) ||
      (1 << SEL_W) < NUM_INPUTS) begin : g_badParams
    $error("mux_n_pipe: illegal parameter combination");
  end

  logic [WIDTH-1:0] w_selData;
  logic             w_selOor;
  logic             w_s1Ready;
  logic             w_accept;
  logic             r_s1Valid;
  logic [WIDTH-1:0] r_s1Data;
  logic             r_selErr;
  logic [7:0]       r_errCount;

  always_comb begin
    w_selData = DEFAULT_VAL;
    for (int k = 0; k < NUM_INPUTS; k++) begin
      if (32'(sel) == k) w_selData = in_data[k*WIDTH +: WIDTH];
    end
  end

  assign w_selOor = (32'(sel) >= 32'(NUM_INPUTS));
  // Reset holds the pipe closed so nothing is accepted while it is being flushed.
  assign in_ready = !reset && w_s1Ready;
  assign w_accept = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1Valid <= 1'b0;
      r_s1Data  <= '0;
    end else if (w_s1Ready) begin
      r_s1Valid <= in_valid;
      if (in_valid) r_s1Data <= w_selData;
    end
  end

  if (PIPE_STAGES == 2) begin : g_twoStage
    logic             r_s2Valid;
    logic [WIDTH-1:0] r_s2Data;
    logic             w_s2Ready;

    assign w_s2Ready = !r_s2Valid || out_ready;
    // Stage 1 may refill while stage 2 stalls, as long as its own entry can move on.
    assign w_s1Ready = !r_s1Valid || w_s2Ready;

    always_ff @(posedge clk) begin
      if (reset) begin
        r_s2Valid <= 1'b0;
        r_s2Data  <= '0;
      end else if (w_s2Ready) begin
        r_s2Valid <= r_s1Valid;
        if (r_s1Valid) r_s2Data <= r_s1Data;
      end
    end

    assign out_valid = r_s2Valid;
    assign out_data  = r_s2Data;
  end else begin : g_oneStage
    assign w_s1Ready = !r_s1Valid || out_ready;
    assign out_valid = r_s1Valid;
    assign out_data  = r_s1Data;
  end

  // A clear wins over a same-cycle bad select, which is then not counted.
  always_ff @(posedge clk) begin
    if (reset || err_clr) begin
      r_selErr   <= 1'b0;
      r_errCount <= 8'd0;
    end else if (w_accept && w_selOor) begin
      r_selErr <= 1'b1;
      if (r_errCount != 8'hFF) r_errCount <= r_errCount + 8'd1;
    end
  end

  assign sel_err   = r_selErr;
  assign err_count = r_errCount;

endmodule
